// File: rtl/ex_muldiv_unit_if.sv
// Bus between the ID/EX stage and the EX multiply/divide unit.
// The master is the pipeline; the slave is ex_muldiv_unit.
`timescale 1ns/1ps
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One multiplier or quotient bit per cycle over WIDTH RUN cycles, then a FIX
// cycle applies signs and special cases and commits HI/LO.
`timescale 1ns/1ps
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  // Upper half: partial product (mul) or partial remainder (div).
  // Lower half: multiplier being shifted out (mul) or dividend/quotient (div).
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_raw_a;    // raw rs_val, needed for divide-by-zero HI
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_dbz;
  logic               r_done;

  logic               w_busy;
  logic               w_accept;
  logic               w_run;
  logic               w_commit;
  logic               w_last;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; flush squashes the op from RUN or FIX, and cancels an idle start.
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && !bus.flush) w_next = S_RUN;
      S_RUN:   if (bus.flush)               w_next = S_IDLE;
               else if (w_last)             w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    w_run    = (r_state == S_RUN);
    w_commit = (r_state == S_FIX) && !bus.flush;
  end

  // Operand magnitudes and sign flags captured at issue.
  always_comb begin
    w_signed = !bus.op[0];
    w_mag_a  = (w_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    w_mag_b  = (w_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opb};
    if (r_is_div) begin
      if (w_diff[WIDTH]) w_step = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else               w_step = {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_step = {w_add, r_acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up and special cases applied in FIX.
  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (!r_is_div) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_dbz) begin
      w_res_hi = r_raw_a;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  // Iteration datapath: load at issue, step once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_raw_a  <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
      r_opb    <= w_mag_b;
      r_raw_a  <= bus.rs_val;
      r_is_div <= bus.op[1];
      r_neg_a  <= w_signed && bus.rs_val[WIDTH-1];
      r_neg_b  <= w_signed && bus.rt_val[WIDTH-1];
      r_dbz    <= (bus.rt_val == '0);
    end else if (w_run) begin
      r_cnt    <= r_cnt + CW'(1);
      r_acc    <= w_step;
    end
  end

  // HI/LO: op result in FIX, otherwise MTHI/MTLO while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (!w_busy) begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected {HI,LO} from an
// arithmetic reference model; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_entry_t sb_q[$];

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: architectural MIPS HI/LO semantics with plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  // Drives one start edge (caller sits just after a rising edge); clears one-shot controls after it.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_accept);
    sb_entry_t e;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    if (expect_accept) begin
      e.name = name;
      e.exp  = model(op, a, b);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) check("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Counts rising edges from the start edge until done is seen.
  task automatic measure_latency(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 60);
    check(name, 64'(n), 64'd33);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        if (sb_q.size() == 0) begin
          check("done_without_pending_op", 64'(bus.done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hilo"}, {bus.hi, bus.lo}, e.exp);
          check({e.name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.flush = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle MTHI/MTLO, then reset in the middle of MULTU 5*7.
    bus.mthi = 1'b1; bus.wdata = 32'h0000_0011;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h0000_0022;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mthi_idle", 64'(bus.hi), 64'h11);
    check("mtlo_idle", 64'(bus.lo), 64'h22);
    issue("multu_reset", OP_MULTU, 32'd5, 32'd7, 0);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_busy", 64'(bus.busy), 64'd0);
    check("midrun_reset_done", 64'(bus.done), 64'd0);
    check("midrun_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Full-range MULTU with latency check, then back-to-back start in the done cycle.
    issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    measure_latency("multu_max_latency");
    issue("b2b_mult", OP_MULT, -32'sd3, 32'sd7, 1);
    measure_latency("b2b_latency");
    issue("div_neg7_2", OP_DIV, -32'sd7, 32'sd2, 1);
    wait_idle();
    issue("divu_by_zero", OP_DIVU, 32'd100, 32'd0, 1);
    wait_idle();
    issue("div_by_zero_signed", OP_DIV, 32'hFFFF_FFF0, 32'd0, 1);
    wait_idle();
    issue("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle();

    // MTHI in the same edge as start lands first; MTHI while busy is dropped.
    bus.mthi = 1'b1; bus.wdata = 32'h0000_CAFE;
    issue("multu_mthi_same_edge", OP_MULTU, 32'd5, 32'd7, 1);
    check("mthi_with_start", 64'(bus.hi), 64'hCAFE);
    bus.mthi = 1'b1; bus.wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check("mthi_while_busy", 64'(bus.hi), 64'hCAFE);
    // Second start while busy is ignored.
    repeat (3) @(posedge clk);
    #1;
    issue("ignored_start", OP_DIVU, 32'd9, 32'd3, 0);
    wait_idle();
    repeat (40) @(posedge clk);
    #1;

    // MTLO then DIV flushed at cycle 10: LO kept, no done.
    bus.mtlo = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mtlo_before_flush", 64'(bus.lo), 64'h1234);
    issue("div_flushed", OP_DIV, 32'd1000, 32'd7, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_run_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_lo_kept", 64'(bus.lo), 64'h1234);

    // Flush together with an idle start cancels it.
    bus.flush = 1'b1;
    issue("start_with_flush", OP_MULTU, 32'd3, 32'd3, 0);
    check("flush_cancels_start", 64'(bus.busy), 64'd0);

    // Flush on the FIX edge wins over the commit.
    issue("fix_flushed", OP_MULTU, 32'd11, 32'd13, 0);
    repeat (32) @(posedge clk);
    #1;
    check("in_fix_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_fix_busy", 64'(bus.busy), 64'd0);
    check("flush_fix_done", 64'(bus.done), 64'd0);
    check("flush_fix_lo_kept", 64'(bus.lo), 64'h1234);
    repeat (5) @(posedge clk);
    #1;

    // Randomized ops with corner cases mixed in.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = -32'($urandom_range(1, 1000));
        4: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      wait_idle();
      issue($sformatf("rand%0d_op%0d", i, op), op, a, b, 1);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
